// File: rtl/turtle_issue_if.sv
// Decode/execute/writeback handshake bundle for the Turtle issue controller.
//   master : decoder + datapath side (drives decode fields, ex_rdy, flush, writeback)
//   slave  : turtle_issue_ctrl (drives de_rdy, issue, execute register, status)
interface turtle_issue_if #(
    parameter int CNT_W = 16
);
    logic             de_vld;
    logic             de_rdy;
    logic             de_rs1_vld;
    logic [4:0]       de_rs1;
    logic             de_rs2_vld;
    logic [4:0]       de_rs2;
    logic             de_rd_vld;
    logic [4:0]       de_rd;
    logic             de_load;
    logic             issue;
    logic             ex_vld;
    logic             ex_rdy;
    logic [4:0]       ex_rd;
    logic             ex_load;
    logic             flush;
    logic             wb_vld;
    logic [4:0]       wb_rd;
    logic [2:0]       pend_cnt;
    logic [CNT_W-1:0] stall_cnt;
    logic             err;

    modport master (
        output de_vld, de_rs1_vld, de_rs1, de_rs2_vld, de_rs2, de_rd_vld, de_rd, de_load,
               ex_rdy, flush, wb_vld, wb_rd,
        input  de_rdy, issue, ex_vld, ex_rd, ex_load, pend_cnt, stall_cnt, err
    );

    modport slave (
        input  de_vld, de_rs1_vld, de_rs1, de_rs2_vld, de_rs2, de_rd_vld, de_rd, de_load,
               ex_rdy, flush, wb_vld, wb_rd,
        output de_rdy, issue, ex_vld, ex_rd, ex_load, pend_cnt, stall_cnt, err
    );
endinterface

// File: rtl/turtle_issue_ctrl.sv
// Issue/hazard controller between the Turtle decoder and the execute stage.
// Owns the decode->execute valid bit, a scoreboard of registers with loads
// still outstanding, the in-flight load count, a saturating stall counter and
// a sticky error flag for writebacks to registers that were never pending.
// Ports:
//   clk, rst : core clock, synchronous active-high reset
//   bus      : turtle_issue_if.slave (decode fields, execute register,
//              flush, load writeback, status outputs)
module turtle_issue_ctrl #(
    parameter int PENDING_MAX = 2,
    parameter int CNT_W       = 16
) (
    input  logic            clk,
    input  logic            rst,
    turtle_issue_if.slave   bus
);
    logic [31:0]      pend;
    logic             ex_vld;
    logic [4:0]       ex_rd;
    logic             ex_load;
    logic [2:0]       pend_cnt;
    logic [CNT_W-1:0] stall_cnt;
    logic             err;

    logic wb_hit1, wb_hit2, wb_hitd;
    logic wb_clr, raw, waw, full, hazard;
    logic de_rdy, issue, pend_set;

    // Register file is write-first, so a same-cycle writeback already
    // resolves the dependency.
    assign wb_hit1 = bus.wb_vld && (bus.wb_rd == bus.de_rs1);
    assign wb_hit2 = bus.wb_vld && (bus.wb_rd == bus.de_rs2);
    assign wb_hitd = bus.wb_vld && (bus.wb_rd == bus.de_rd);

    // pend[0] is never set, so this also rejects writebacks to x0.
    assign wb_clr = bus.wb_vld && pend[bus.wb_rd];

    assign raw = (bus.de_rs1_vld && (bus.de_rs1 != 5'd0) && pend[bus.de_rs1] && !wb_hit1) ||
                 (bus.de_rs2_vld && (bus.de_rs2 != 5'd0) && pend[bus.de_rs2] && !wb_hit2);
    assign waw = bus.de_rd_vld && (bus.de_rd != 5'd0) && pend[bus.de_rd] && !wb_hitd;

    // A retiring load this cycle frees a slot for a new one.
    assign full = bus.de_load && ((pend_cnt - {2'b00, wb_clr}) == 3'(PENDING_MAX));

    assign hazard = raw || waw || full;

    assign de_rdy   = !rst && !bus.flush && !hazard && (!ex_vld || bus.ex_rdy);
    assign issue    = bus.de_vld && de_rdy;
    // Scoreboard is armed at issue so the very next instruction sees it.
    assign pend_set = issue && bus.de_load && bus.de_rd_vld && (bus.de_rd != 5'd0);

    // Execute pipeline register
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_vld  <= 1'b0;
            ex_rd   <= 5'd0;
            ex_load <= 1'b0;
        end else if (bus.flush) begin
            ex_vld  <= 1'b0;
        end else if (issue) begin
            ex_vld  <= 1'b1;
            ex_rd   <= bus.de_rd_vld ? bus.de_rd : 5'd0;
            ex_load <= bus.de_load;
        end else if (bus.ex_rdy) begin
            ex_vld  <= 1'b0;
        end
    end

    // Load scoreboard and in-flight count; flush leaves both alone because
    // loads already handed to the LSU still write back.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend     <= '0;
            pend_cnt <= 3'd0;
        end else begin
            // Clear first, then set, so a same-register set wins.
            if (wb_clr)
                pend[bus.wb_rd] <= 1'b0;
            if (pend_set)
                pend[bus.de_rd] <= 1'b1;
            if (pend_set && !wb_clr)
                pend_cnt <= pend_cnt + 3'd1;
            else if (wb_clr && !pend_set)
                pend_cnt <= pend_cnt - 3'd1;
        end
    end

    // Stall counter and sticky error
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            err       <= 1'b0;
        end else begin
            if (bus.de_vld && hazard && !bus.flush && !(&stall_cnt))
                stall_cnt <= stall_cnt + 1'b1;
            if (bus.wb_vld && !wb_clr)
                err <= 1'b1;
        end
    end

    assign bus.de_rdy    = de_rdy;
    assign bus.issue     = issue;
    assign bus.ex_vld    = ex_vld;
    assign bus.ex_rd     = ex_rd;
    assign bus.ex_load   = ex_load;
    assign bus.pend_cnt  = pend_cnt;
    assign bus.stall_cnt = stall_cnt;
    assign bus.err       = err;
endmodule

// File: tb/tb_turtle_issue_ctrl.sv
// Directed bench for turtle_issue_ctrl. Each step drives decode/writeback
// inputs, checks the combinational ready/issue, queues the expected
// post-edge register state, and compares it after the clock edge.
// CNT_W is kept at 2 so stall-counter saturation is reachable.
module tb_turtle_issue_ctrl;
    localparam int CNT_W = 2;

    typedef struct {
        string      tag;
        bit         exv;
        bit [4:0]   exrd;
        bit         exld;
        bit [2:0]   pc;
        int         sc;
        bit         err;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t sb[$];

    turtle_issue_if #(.CNT_W(CNT_W)) bus ();

    turtle_issue_ctrl #(.PENDING_MAX(2), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic din(input bit v, input bit r1v, input bit [4:0] r1,
                       input bit r2v, input bit [4:0] r2,
                       input bit rdv, input bit [4:0] rd, input bit ld);
        bus.de_vld     = v;
        bus.de_rs1_vld = r1v;
        bus.de_rs1     = r1;
        bus.de_rs2_vld = r2v;
        bus.de_rs2     = r2;
        bus.de_rd_vld  = rdv;
        bus.de_rd      = rd;
        bus.de_load    = ld;
    endtask

    task automatic wb(input bit v, input bit [4:0] rd);
        bus.wb_vld = v;
        bus.wb_rd  = rd;
    endtask

    // Called at negedge with inputs already driven.
    task automatic step(input string tag, input bit rdy, input bit exv,
                        input bit [4:0] exrd, input bit exld,
                        input bit [2:0] pc, input int sc, input bit err);
        exp_t e, g;
        #1;
        chk({tag, ".rdy"},   32'(bus.de_rdy), 32'(rdy));
        chk({tag, ".issue"}, 32'(bus.issue),  32'(bus.de_vld & rdy));
        e.tag = tag; e.exv = exv; e.exrd = exrd; e.exld = exld;
        e.pc = pc; e.sc = sc; e.err = err;
        sb.push_back(e);
        @(posedge clk);
        #1;
        g = sb.pop_front();
        chk({g.tag, ".exv"},  32'(bus.ex_vld),    32'(g.exv));
        chk({g.tag, ".exrd"}, 32'(bus.ex_rd),     32'(g.exrd));
        chk({g.tag, ".exld"}, 32'(bus.ex_load),   32'(g.exld));
        chk({g.tag, ".pc"},   32'(bus.pend_cnt),  32'(g.pc));
        chk({g.tag, ".sc"},   32'(bus.stall_cnt), 32'(g.sc));
        chk({g.tag, ".err"},  32'(bus.err),       32'(g.err));
        @(negedge clk);
    endtask

    initial begin
        din(1, 0, 0, 0, 0, 1, 4, 0);
        wb(0, 0);
        bus.ex_rdy = 1'b1;
        bus.flush  = 1'b0;
        @(negedge clk);

        // reset holds everything at zero and blocks issue
        step("rst",      0, 0, 0,  0, 0, 0, 0);
        rst = 1'b0;

        // load x5, dependent add stalls until writeback
        din(1, 1, 2, 0, 0, 1, 5, 1);  step("ld5",     1, 1, 5,  1, 1, 0, 0);
        din(1, 1, 5, 0, 0, 1, 6, 0);  step("raw1",    0, 0, 5,  1, 1, 1, 0);
                                      step("raw2",    0, 0, 5,  1, 1, 2, 0);
        wb(1, 5);                     step("rawwb",   1, 1, 6,  0, 0, 2, 0);
        wb(0, 0);

        // load to x0 is not tracked; x0 consumer goes straight through
        din(1, 0, 0, 0, 0, 1, 0, 1);  step("ld0",     1, 1, 0,  1, 0, 2, 0);
        din(1, 1, 0, 0, 0, 1, 7, 0);  step("use0",    1, 1, 7,  0, 0, 2, 0);

        // in-flight load limit
        din(1, 0, 0, 0, 0, 1, 1, 1);  step("ld1",     1, 1, 1,  1, 1, 2, 0);
        din(1, 0, 0, 0, 0, 1, 2, 1);  step("ld2",     1, 1, 2,  1, 2, 2, 0);
        din(1, 0, 0, 0, 0, 1, 3, 1);  step("full",    0, 0, 2,  1, 2, 3, 0);
        wb(1, 1);                     step("fullwb",  1, 1, 3,  1, 2, 3, 0);
        wb(0, 0);

        // execute backpressure
        bus.ex_rdy = 1'b0;
        din(1, 1, 10, 0, 0, 1, 11, 0); step("bp1",    0, 1, 3,  1, 2, 3, 0);
                                       step("bp2",    0, 1, 3,  1, 2, 3, 0);
        bus.ex_rdy = 1'b1;             step("bpgo",   1, 1, 11, 0, 2, 3, 0);
        din(1, 0, 0, 0, 0, 1, 12, 0);  step("b2b",    1, 1, 12, 0, 2, 3, 0);

        // flush with a hazarding instruction: no issue, no stall count
        bus.flush = 1'b1;
        din(1, 1, 2, 0, 0, 1, 13, 0);  step("flush",  0, 0, 12, 0, 2, 3, 0);
        bus.flush = 1'b0;

        // writeback to non-pending register sets sticky error
        din(0, 0, 0, 0, 0, 0, 0, 0);
        wb(1, 9);                      step("err",    1, 0, 12, 0, 2, 3, 1);
        wb(0, 0);                      step("errhold",1, 0, 12, 0, 2, 3, 1);
        wb(1, 2);                      step("clr2",   1, 0, 12, 0, 1, 3, 1);

        // same-register set and clear: set wins, count unchanged
        din(1, 0, 0, 0, 0, 1, 3, 1);
        wb(1, 3);                      step("setclr", 1, 1, 3,  1, 1, 3, 1);
        wb(0, 0);
        din(1, 1, 3, 0, 0, 1, 14, 0);  step("sat",    0, 0, 3,  1, 1, 3, 1);

        // mid-operation reset
        rst = 1'b1;
        din(0, 0, 0, 0, 0, 0, 0, 0);   step("rst2",   0, 0, 0,  0, 0, 0, 0);
        rst = 1'b0;
        din(1, 1, 3, 0, 0, 1, 14, 0);  step("postrst",1, 1, 14, 0, 0, 0, 0);

        chk("sb.empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/turtle_issue_ctrl.md
Name: turtle_issue_ctrl

Overview:
Issue/hazard controller between the Turtle decoder and the integer/LSU execute stage. Holds the decode-to-execute pipeline register valid bit and a load scoreboard of registers with outstanding load writebacks. Stalls decode on RAW/WAW hazards against pending loads, limits in-flight loads, and drops the issued instruction on a branch/jump flush. Payload (decoded s1/s2/offset/control bundles) is registered by the datapath using oIssue as its enable.

Parameters:
PENDING_MAX, 2, maximum outstanding loads (1..7)
CNT_W, 16, width of saturating stall-cycle counter

Ports:
clk  input  1  core clock
rst  input  1  reset; synchronous, active-high (already decided)
iDeVld  input  1  decoder holds a valid instruction
oDeRdy  output  1  controller accepts the instruction this cycle
iDeRs1Vld  input  1  rs1 used
iDeRs1  input  5  rs1 index
iDeRs2Vld  input  1  rs2 used
iDeRs2  input  5  rs2 index
iDeRdVld  input  1  rd written
iDeRd  input  5  rd index
iDeLoad  input  1  instruction is a load
oIssue  output  1  iDeVld & oDeRdy; payload-register load enable
oExVld  output  1  execute-stage register valid
iExRdy  input  1  execute stage consumes oExVld this cycle
oExRd  output  5  registered rd of issued instruction (0 if no rd)
oExLoad  output  1  registered load flag
iFlush  input  1  branch/jump redirect; kill execute register and decode
iWbVld  input  1  LSU load writeback valid
iWbRd  input  5  load writeback register
oPendCnt  output  3  outstanding load count
oStallCnt  output  CNT_W  saturating count of hazard-stall cycles
oErr  output  1  sticky: writeback to a non-pending register

Behaviour:
- Reset: pend mask, oExVld, oExRd, oExLoad, oPendCnt, oStallCnt, oErr all 0; oDeRdy/oIssue 0 while rst high.
- pend[31:0]: bit 0 never set. wbHit(r) = iWbVld & iWbRd==r (RF is write-first, so same-cycle writeback resolves the hazard).
- raw = (iDeRs1Vld & iDeRs1!=0 & pend[iDeRs1] & !wbHit(iDeRs1)) | same for rs2.
- waw = iDeRdVld & iDeRd!=0 & pend[iDeRd] & !wbHit(iDeRd).
- full = iDeLoad & (oPendCnt - (iWbVld & pend[iWbRd]) == PENDING_MAX).
- hazard = raw | waw | full.
- oDeRdy = !rst & !iFlush & !hazard & (!oExVld | iExRdy). Combinational; zero-cycle decision, one-cycle issue latency to oExVld.
- Execute register next state: iFlush -> oExVld=0; else oIssue -> oExVld=1, oExRd=iDeRdVld?iDeRd:0, oExLoad=iDeLoad; else iExRdy -> oExVld=0; else hold.
- Scoreboard set at issue (not at execute) when oIssue & iDeLoad & iDeRdVld & iDeRd!=0. Clear when iWbVld & pend[iWbRd]. Same register set and clear in same cycle: set wins.
- oPendCnt: +1 on set, -1 on clear, both -> unchanged. Never exceeds PENDING_MAX.
- Flush does not clear pend or oPendCnt: issued loads already in LSU still write back. A load killed in the execute register by iFlush must be reported by the LSU as a writeback (datapath guarantee); the controller does not track it separately.
- iWbVld with iWbRd==0 or !pend[iWbRd]: no state change except oErr<=1 (sticky until reset).
- oStallCnt increments when iDeVld & hazard & !iFlush; saturates at all-ones.
- Reset mid-operation: all state cleared next edge regardless of pending writebacks.

Test Plan:
- Load x5 issued (iDeLoad=1, rd=5), next cycle add rs1=5 with iDeVld=1 -> oDeRdy=0, oStallCnt increments each cycle; iWbVld=1 iWbRd=5 -> same cycle oDeRdy=1, pend[5] clears, oPendCnt 1->0.
- Load x0 issued -> pend unchanged, oPendCnt stays 0; following rs1=0 consumer issues back-to-back.
- PENDING_MAX=2: loads to x1, x2 issued, third load to x3 -> stalled while oPendCnt=2; writeback x1 same cycle -> third load issues, oPendCnt stays 2.
- iExRdy=0 with oExVld=1 -> oDeRdy=0 and oExRd/oExLoad hold; iExRdy=1 -> back-to-back issue with oExVld staying 1.
- iFlush=1 while oExVld=1 and decoder valid -> next cycle oExVld=0, no issue, pend unchanged.
- iWbVld=1 iWbRd=9 with pend[9]=0 -> oErr=1 and stays set; oPendCnt unchanged; rst=1 -> oErr=0, oStallCnt=0.
